// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial adder/subtractor.
// Processes CHUNK bits per cycle, LSB slice first, over N = WIDTH/CHUNK cycles.
// The optional signed-overflow flag is built only when the macro
// ADDSUB_SERIAL_OVF_EN is defined; otherwise ovf is tied to 0.

module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic               busy_r;
    logic               done_r;
    logic               busy_nx_s;
    logic               done_nx_s;

    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               sub_r;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   result_r;
    logic               cout_r;

    logic               accept_s;
    logic               last_s;
    logic [WIDTH-1:0]   b_eff_s;
    logic [CHUNK-1:0]   slice_a_s;
    logic [CHUNK-1:0]   slice_b_s;
    logic [CHUNK:0]     sum_s;
    logic [WIDTH-1:0]   result_nx_s;

    // A start is honoured only when no operation is running.
    assign accept_s = start && (state_r != ST_BUSY);
    assign last_s   = (cnt_r == CNT_W'(N - 1));
    assign b_eff_s  = sub_r ? ~b_r : b_r;

    // State register plus registered busy/done flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= busy_nx_s;
            done_r  <= done_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nx_s = ST_BUSY;
                else       state_nx_s = ST_IDLE;
            end
            ST_BUSY: begin
                if (last_s) state_nx_s = ST_DONE;
                else        state_nx_s = ST_BUSY;
            end
            ST_DONE: begin
                if (start) state_nx_s = ST_BUSY;
                else       state_nx_s = ST_IDLE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state so busy/done come straight from flops.
    always_comb begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
        case (state_nx_s)
            ST_IDLE: begin
                busy_nx_s = 1'b0;
                done_nx_s = 1'b0;
            end
            ST_BUSY: begin
                busy_nx_s = 1'b1;
                done_nx_s = 1'b0;
            end
            ST_DONE: begin
                busy_nx_s = 1'b0;
                done_nx_s = 1'b1;
            end
            default: begin
                busy_nx_s = 1'b0;
                done_nx_s = 1'b0;
            end
        endcase
    end

    // Select the active slice, add it, and splice the sum into the result.
    always_comb begin
        slice_a_s   = {CHUNK{1'b0}};
        slice_b_s   = {CHUNK{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (cnt_r == CNT_W'(i)) begin
                slice_a_s = a_r[i*CHUNK +: CHUNK];
                slice_b_s = b_eff_s[i*CHUNK +: CHUNK];
            end else begin
                slice_a_s = slice_a_s;
                slice_b_s = slice_b_s;
            end
        end
        sum_s       = {1'b0, slice_a_s} + {1'b0, slice_b_s} + {{CHUNK{1'b0}}, carry_r};
        result_nx_s = result_r;
        for (int i = 0; i < N; i++) begin
            if (cnt_r == CNT_W'(i)) begin
                result_nx_s[i*CHUNK +: CHUNK] = sum_s[CHUNK-1:0];
            end else begin
                result_nx_s[i*CHUNK +: CHUNK] = result_r[i*CHUNK +: CHUNK];
            end
        end
    end

    // Operand capture and slice-by-slice datapath; the carry register is
    // seeded with cin so slice 0 sees the captured carry-in.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            sub_r    <= 1'b0;
            carry_r  <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            result_r <= {WIDTH{1'b0}};
            cout_r   <= 1'b0;
        end else if (accept_s) begin
            a_r      <= a;
            b_r      <= b;
            sub_r    <= sub;
            carry_r  <= cin;
            cnt_r    <= {CNT_W{1'b0}};
            result_r <= {WIDTH{1'b0}};
            cout_r   <= 1'b0;
        end else if (state_r == ST_BUSY) begin
            result_r <= result_nx_s;
            carry_r  <= sum_s[CHUNK];
            if (last_s) begin
                cout_r <= sum_s[CHUNK];
                cnt_r  <= cnt_r;
            end else begin
                cout_r <= cout_r;
                cnt_r  <= cnt_r + CNT_W'(1);
            end
        end else begin
            result_r <= result_r;
            cout_r   <= cout_r;
        end
    end

`ifdef ADDSUB_SERIAL_OVF_EN
    logic ovf_r;
    logic ovf_s;

    // Signed overflow: like-signed operands producing a result of the other sign.
    assign ovf_s = (a_r[WIDTH-1] == b_eff_s[WIDTH-1]) &&
                   (sum_s[CHUNK-1] != a_r[WIDTH-1]);

    // Overflow flag register, updated on the final slice only.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (accept_s) begin
            ovf_r <= 1'b0;
        end else if ((state_r == ST_BUSY) && last_s) begin
            ovf_r <= ovf_s;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign cout   = cout_r;

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial (WIDTH=16, CHUNK=4).
// Reference results come from whole-word integer arithmetic.

module tb_addsub_serial;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int n_total;
    int n_bad;

    logic [W-1:0] last_r;
    logic         last_co;
    logic         last_ov;

    addsub_serial #(.WIDTH(W), .CHUNK(C)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .sub    (sub),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Whole-word reference: result, carry-out and signed overflow.
    function automatic void model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                  input logic is, input logic ic,
                                  output logic [W-1:0] r, output logic co, output logic ov);
        logic [W-1:0] be;
        logic [W:0]   t;
        int           st;
        be = is ? ~ib : ib;
        t  = {1'b0, ia} + {1'b0, be} + {{W{1'b0}}, ic};
        r  = t[W-1:0];
        co = t[W];
        st = int'($signed(ia)) + int'($signed(be)) + int'(ic);
`ifdef ADDSUB_SERIAL_OVF_EN
        ov = (st > 32767) || (st < -32768);
`else
        ov = 1'b0;
`endif
    endfunction

    // Runs one operation; caller is #1 after a posedge with the DUT in IDLE or DONE.
    // Leaves the bench #1 after the edge that enters DONE.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic is, input logic ic, input bit mid_start);
        logic [W-1:0] r;
        logic         co;
        logic         ov;
        logic [31:0]  mask;
        model(ia, ib, is, ic, r, co, ov);
        start = 1'b1; a = ia; b = ib; sub = is; cin = ic;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        for (int k = 0; k < N; k++) begin
            mask = (32'd1 << (C * k)) - 32'd1;
            check_val("busy", {31'd0, busy}, 32'd1);
            check_val("done_in_busy", {31'd0, done}, 32'd0);
            check_val("partial", {16'd0, result}, {16'd0, r} & mask);
            if (k == 0) begin
                check_val("cout_clr", {31'd0, cout}, 32'd0);
                check_val("ovf_clr", {31'd0, ovf}, 32'd0);
            end
            start = (mid_start && k == 1) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check_val("done", {31'd0, done}, 32'd1);
        check_val("busy_end", {31'd0, busy}, 32'd0);
        check_val("result", {16'd0, result}, {16'd0, r});
        check_val("cout", {31'd0, cout}, {31'd0, co});
        check_val("ovf", {31'd0, ovf}, {31'd0, ov});
        last_r = r; last_co = co; last_ov = ov;
    endtask

    // One idle cycle after DONE: flags drop, final values hold.
    task automatic idle_check();
        @(posedge clk); #1;
        check_val("idle_done", {31'd0, done}, 32'd0);
        check_val("idle_busy", {31'd0, busy}, 32'd0);
        check_val("hold_result", {16'd0, result}, {16'd0, last_r});
        check_val("hold_cout", {31'd0, cout}, {31'd0, last_co});
        check_val("hold_ovf", {31'd0, ovf}, {31'd0, last_ov});
    endtask

    initial begin
        n_total = 0; n_bad = 0;
        rst = 1'b1; start = 1'b0; a = 16'h0000; b = 16'h0000; sub = 1'b0; cin = 1'b0;
        last_r = 16'h0000; last_co = 1'b0; last_ov = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_result", {16'd0, result}, 32'd0);
        check_val("rst_cout", {31'd0, cout}, 32'd0);
        check_val("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0);
        check_val("ex_add", {16'd0, result}, 32'h2233);
        idle_check();
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
        check_val("ex_sub", {16'd0, result}, 32'hFFFE);
        check_val("ex_sub_cout", {31'd0, cout}, 32'd0);
        idle_check();
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        check_val("ex_ovf_res", {16'd0, result}, 32'h8000);
        idle_check();
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        check_val("ex_wrap_res", {16'd0, result}, 32'h0000);
        check_val("ex_wrap_cout", {31'd0, cout}, 32'd1);
        idle_check();

        // Start pulse mid-operation is ignored.
        do_op(16'hA5A5, 16'h1357, 1'b1, 1'b1, 1'b1);
        // Start held in DONE: back-to-back operations.
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
        do_op(16'h4000, 16'hC000, 1'b1, 1'b1, 1'b0);
        idle_check();

        // Reset during BUSY: rst sampled at T+2.
        start = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("mrst_busy", {31'd0, busy}, 32'd0);
        check_val("mrst_done", {31'd0, done}, 32'd0);
        check_val("mrst_result", {16'd0, result}, 32'd0);
        check_val("mrst_cout", {31'd0, cout}, 32'd0);
        check_val("mrst_ovf", {31'd0, ovf}, 32'd0);
        for (int k = 0; k < N + 2; k++) begin
            @(posedge clk); #1;
            check_val("mrst_nodone", {31'd0, done}, 32'd0);
        end
        last_r = 16'h0000; last_co = 1'b0; last_ov = 1'b0;

        // Randomized operations, some back-to-back, some with mid-run start pulses.
        for (int i = 0; i < 30; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) idle_check();
        end
        idle_check();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 Parameter WIDTH, default 16, shall set the operand and result width in bits.
REQ-002 Parameter CHUNK, default 4, shall set the bits processed per cycle; WIDTH shall be an integer multiple of CHUNK, and N = WIDTH/CHUNK.
REQ-003 The block shall use one clock and a synchronous, active-high reset.
REQ-004 Ports shall be:
- clk    in   1      clock, rising edge
- rst    in   1      synchronous active-high reset
- start  in   1      request, sampled in IDLE or DONE
- a      in   WIDTH  minuend / augend
- b      in   WIDTH  subtrahend / addend
- sub    in   1      1 = subtract (B inverted), 0 = add
- cin    in   1      carry-in to bit 0 (1 for true two's-complement subtract)
- busy   out  1      operation in progress
- done   out  1      one-cycle completion pulse
- result out  WIDTH  sum/difference
- cout   out  1      carry out of MSB (for subtract, 1 = no borrow)
- ovf    out  1      signed overflow

Function
REQ-005 The state machine shall have states IDLE, BUSY and DONE.
REQ-006 When start=1 in IDLE or DONE at edge T, the block shall capture a, b, sub and cin, clear its chunk counter, and enter BUSY.
REQ-007 While in BUSY, each cycle shall compute one CHUNK slice, LSB slice first: slice(a) + slice(sub ? ~b : b) + carry, where the carry is the captured cin for slice 0 and the registered carry from the previous slice thereafter.
REQ-008 Each computed slice shall be written into result in place; upper slices not yet computed shall hold 0.
REQ-009 BUSY shall last exactly N cycles; after the Nth slice the FSM shall enter DONE, giving done=1 for the single cycle T+N+1.
REQ-010 DONE shall return to IDLE after one cycle unless start=1, in which case it shall go to BUSY per REQ-006.
REQ-011 busy shall be 1 exactly while in BUSY, and done shall be 1 exactly while in DONE.
REQ-012 start shall be ignored while in BUSY; captured operands shall not change.
REQ-013 result, cout and ovf shall hold their final values from DONE until the next accepted start, which shall clear them to 0.
REQ-014 cout shall be the carry out of the final slice.
REQ-015 ovf shall be computed from the MSBs of a, of the effective B, and of result: 1 when the operand signs are equal and the result sign differs.
REQ-016 Arithmetic shall wrap modulo 2^WIDTH without saturation.

Reset
REQ-017 When rst=1 at a clock edge, the block shall enter IDLE and drive busy=0, done=0, result=0, cout=0 and ovf=0, with the counter, carry and operand registers cleared.
REQ-018 Reset shall take priority over start, and a reset during BUSY shall discard the partial result with no done pulse.

Configuration
REQ-019 When macro ADDSUB_SERIAL_OVF_EN is defined, the overflow logic shall be compiled in and ovf shall behave per REQ-015.
REQ-020 When ADDSUB_SERIAL_OVF_EN is undefined, no overflow logic shall be present and ovf shall be constant 0.

Verification (WIDTH=16, CHUNK=4, so N=4)
REQ-021 Add: a=0x1234, b=0x0FFF, sub=0, cin=0, start at T -> busy T+1..T+4, done at T+5, result=0x2233, cout=0, ovf=0.
REQ-022 Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 -> result=0xFFFE, cout=0, ovf=0.
REQ-023 Overflow and wrap cases:
- a=0x7FFF + b=0x0001 (add, cin=0) -> result=0x8000, cout=0, ovf=1 (ovf=0 without the macro).
- a=0xFFFF + b=0x0001 -> result=0x0000, cout=1, ovf=0.
REQ-024 Start handling: start pulsed at T+2 of a running operation -> ignored, result per the original operands. start held high during the DONE cycle -> new operation accepted with no IDLE cycle between.
REQ-025 Reset mid-operation: rst=1 at T+2 of an operation -> next cycle IDLE with all outputs 0, and no done pulse ever appears for that operation.
